// File: rtl/typing_pkg.sv
// Shared constants and elaboration-time parameter checks for the typed-key
// edge/event counter.
package typing_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  function automatic bit params_ok(input int channels, input int cnt_w, input int sync_stages);
    return (channels >= 1) && (channels <= 16) &&
           (cnt_w >= 1) && (cnt_w <= 16) &&
           ((sync_stages == 0) || (sync_stages == 2) || (sync_stages == 3));
  endfunction

endpackage

// File: rtl/edge_event_chan.sv
// One event channel: optional synchroniser, edge detect with lockout window,
// one-cycle pulse and a saturating event counter.
module edge_event_chan
  import typing_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 0,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int LOCKOUT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             signal,
  output logic             pulse,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int              WARM    = SYNC_STAGES + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync_out;
  logic             cur_reg;
  logic             prev_reg;
  logic [2:0]       warm_reg;
  logic             primed;
  logic             raw_edge;
  logic             lock_idle;
  logic             accept;
  logic [CNT_W-1:0] count_reg;
  logic             sat_reg;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg[0] <= signal;
          for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
        end
      end
      assign sync_out = sync_reg[SYNC_STAGES-1];
    end else begin : g_nosync
      assign sync_out = signal;
    end
  endgenerate

  // Until the pipeline has refilled after reset, prev shadows cur so a level
  // held through reset is never mistaken for an edge.
  assign primed = (warm_reg == 3'(WARM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_reg  <= 1'b0;
      prev_reg <= 1'b0;
      warm_reg <= '0;
    end else begin
      cur_reg  <= sync_out;
      prev_reg <= primed ? cur_reg : sync_out;
      if (!primed) warm_reg <= warm_reg + 3'd1;
    end
  end

  always_comb begin
    raw_edge = cur_reg & ~prev_reg;
    case (EDGE_MODE)
      EDGE_FALL: raw_edge = ~cur_reg & prev_reg;
      EDGE_BOTH: raw_edge = cur_reg ^ prev_reg;
      default:   raw_edge = cur_reg & ~prev_reg;
    endcase
  end

  assign accept = raw_edge & en & lock_idle;

  generate
    if (LOCKOUT > 0) begin : g_lock
      localparam int LW = $clog2(LOCKOUT + 1);
      logic [LW-1:0] lock_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          lock_reg <= '0;
        end else if (accept) begin
          lock_reg <= LW'(LOCKOUT);
        end else if (lock_reg != '0) begin
          lock_reg <= lock_reg - LW'(1);
        end
      end
      assign lock_idle = (lock_reg == '0);
    end else begin : g_nolock
      assign lock_idle = 1'b1;
    end
  endgenerate

  // Clear has priority over a coincident accept; the pulse itself is unaffected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (accept && !sat_reg) begin
      count_reg <= count_reg + CNT_W'(1);
      if (count_reg == CNT_MAX - CNT_W'(1)) sat_reg <= 1'b1;
    end
  end

  assign pulse = accept;
  assign count = count_reg;
  assign sat   = sat_reg;

endmodule

// File: rtl/edge_event_counter.sv
// Multi-channel edge event counter: one edge_event_chan per input bit, with
// packed counters and a combined pulse flag.
module edge_event_counter
  import typing_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 0,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int LOCKOUT     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       signal,
  output logic [CHANNELS-1:0]       pulse,
  output logic                      any_pulse,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic [CHANNELS-1:0]       sat
);

  generate
    if (!params_ok(CHANNELS, CNT_W, SYNC_STAGES) || (EDGE_MODE < EDGE_RISE) ||
        (EDGE_MODE > EDGE_BOTH) || (LOCKOUT < 0)) begin : g_param_err
      $error("edge_event_counter: parameter out of range");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      edge_event_chan #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_MODE  (EDGE_MODE),
        .LOCKOUT    (LOCKOUT)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (clear),
        .signal(signal[gi]),
        .pulse (pulse[gi]),
        .count (count[gi*CNT_W +: CNT_W]),
        .sat   (sat[gi])
      );
    end
  endgenerate

  assign any_pulse = |pulse;

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench for edge_event_counter: four instances covering default,
// lockout, narrow-counter and both-edge/synchronised configurations.
module tb_edge_event_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  // Instance A: defaults
  logic [1:0]  a_sig = 2'b11, a_pulse, a_sat;
  logic        a_en = 1'b1, a_clear = 1'b0, a_any;
  logic [15:0] a_count;
  // Instance B: LOCKOUT=4
  logic [1:0]  b_sig = 2'b00, b_pulse, b_sat;
  logic        b_en = 1'b1, b_clear = 1'b0, b_any;
  logic [15:0] b_count;
  // Instance C: CNT_W=2
  logic [1:0]  c_sig = 2'b00, c_pulse, c_sat;
  logic        c_en = 1'b1, c_clear = 1'b0, c_any;
  logic [3:0]  c_count;
  // Instance D: both edges, two sync stages
  logic [1:0]  d_sig = 2'b00, d_pulse, d_sat;
  logic        d_en = 1'b1, d_clear = 1'b0, d_any;
  logic [15:0] d_count;

  edge_event_counter #(.CHANNELS(2), .CNT_W(8), .SYNC_STAGES(0), .EDGE_MODE(0), .LOCKOUT(0)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .clear(a_clear), .signal(a_sig),
    .pulse(a_pulse), .any_pulse(a_any), .count(a_count), .sat(a_sat));
  edge_event_counter #(.CHANNELS(2), .CNT_W(8), .SYNC_STAGES(0), .EDGE_MODE(0), .LOCKOUT(4)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .clear(b_clear), .signal(b_sig),
    .pulse(b_pulse), .any_pulse(b_any), .count(b_count), .sat(b_sat));
  edge_event_counter #(.CHANNELS(2), .CNT_W(2), .SYNC_STAGES(0), .EDGE_MODE(0), .LOCKOUT(0)) dut_c (
    .clk(clk), .reset(reset), .en(c_en), .clear(c_clear), .signal(c_sig),
    .pulse(c_pulse), .any_pulse(c_any), .count(c_count), .sat(c_sat));
  edge_event_counter #(.CHANNELS(2), .CNT_W(8), .SYNC_STAGES(2), .EDGE_MODE(2), .LOCKOUT(0)) dut_d (
    .clk(clk), .reset(reset), .en(d_en), .clear(d_clear), .signal(d_sig),
    .pulse(d_pulse), .any_pulse(d_any), .count(d_count), .sat(d_sat));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with A's inputs high
    repeat (3) tick();
    check("rst_a_pulse", 32'(a_pulse), 32'd0);
    check("rst_a_count", 32'(a_count), 32'd0);
    check("rst_b_count", 32'(b_count), 32'd0);
    check("rst_c_sat", 32'(c_sat), 32'd0);
    reset = 1'b1;

    // Level held through reset gives no rising pulse
    for (int i = 0; i < 5; i++) begin
      tick();
      check("held_a_pulse", 32'(a_pulse), 32'd0);
      check("held_a_any", 32'(a_any), 32'd0);
    end
    check("held_a_count", 32'(a_count), 32'd0);
    a_sig = 2'b00;
    tick();
    tick();
    a_sig = 2'b11;
    tick();
    check("rearm_a_pulse", 32'(a_pulse), 32'd3);
    tick();
    check("rearm_a_pulse_off", 32'(a_pulse), 32'd0);
    check("rearm_a_count", 32'(a_count), 32'h0101);
    a_sig = 2'b00;
    tick();

    // Single rising edge on channel 0, held five cycles
    a_sig = 2'b01;
    tick();
    check("t1_pulse", 32'(a_pulse), 32'd1);
    check("t1_any", 32'(a_any), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold_pulse", 32'(a_pulse), 32'd0);
    end
    check("t1_count", 32'(a_count), 32'h0102);
    check("t1_sat", 32'(a_sat), 32'd0);
    a_sig = 2'b00;
    tick();

    // Clear coinciding with an accept: pulse kept, count zeroed
    a_sig = 2'b01;
    tick();
    a_clear = 1'b1;
    #1;
    check("clr_pulse", 32'(a_pulse), 32'd1);
    tick();
    a_clear = 1'b0;
    check("clr_count", 32'(a_count), 32'd0);
    check("clr_sat", 32'(a_sat), 32'd0);
    a_sig = 2'b00;

    // Lockout: 1-high/1-low toggling, pulses only every 6th step
    for (int c = 0; c < 13; c++) begin
      b_sig = (c % 2 == 0) ? 2'b01 : 2'b00;
      tick();
      check("lock_pulse", 32'(b_pulse), (c % 6 == 0) ? 32'd1 : 32'd0);
    end
    b_sig = 2'b00;
    tick();
    check("lock_count", 32'(b_count), 32'd3);

    // Saturating 2-bit counter
    for (int k = 0; k < 5; k++) begin
      c_sig = 2'b01;
      tick();
      check("sat_pulse", 32'(c_pulse), 32'd1);
      c_sig = 2'b00;
      tick();
      check("sat_count", 32'(c_count), (k >= 2) ? 32'd3 : 32'(k + 1));
      check("sat_flag", 32'(c_sat), (k >= 2) ? 32'd1 : 32'd0);
    end
    c_clear = 1'b1;
    tick();
    c_clear = 1'b0;
    check("sat_clr_count", 32'(c_count), 32'd0);
    check("sat_clr_flag", 32'(c_sat), 32'd0);

    // Both edges through a 2-stage synchroniser
    d_sig = 2'b10;
    tick();
    check("both_d1", 32'(d_pulse), 32'd0);
    tick();
    check("both_d2", 32'(d_pulse), 32'd0);
    tick();
    check("both_rise", 32'(d_pulse), 32'd2);
    d_sig = 2'b00;
    tick();
    check("both_d4", 32'(d_pulse), 32'd0);
    tick();
    check("both_d5", 32'(d_pulse), 32'd0);
    tick();
    check("both_fall", 32'(d_pulse), 32'd2);
    tick();
    check("both_d7", 32'(d_pulse), 32'd0);
    check("both_count", 32'(d_count), 32'h0200);
    d_en = 1'b0;
    d_sig = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dis_pulse", 32'(d_pulse), 32'd0);
    end
    check("dis_count", 32'(d_count), 32'h0200);
    d_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reen_pulse", 32'(d_pulse), 32'd0);
    end
    check("reen_count", 32'(d_count), 32'h0200);

    // Bring B's count to 5 with the lockout timer running, then reset mid-cycle
    repeat (6) tick();
    b_sig = 2'b01;
    tick();
    check("b4_pulse", 32'(b_pulse), 32'd1);
    b_sig = 2'b00;
    repeat (5) tick();
    b_sig = 2'b01;
    tick();
    check("b5_pulse", 32'(b_pulse), 32'd1);
    b_sig = 2'b00;
    tick();
    check("b5_count", 32'(b_count), 32'd5);
    #3;
    reset = 1'b0;
    #1;
    check("async_b_count", 32'(b_count), 32'd0);
    check("async_b_pulse", 32'(b_pulse), 32'd0);
    check("async_d_count", 32'(d_count), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("post_b_pulse", 32'(b_pulse), 32'd0);
    b_sig = 2'b01;
    tick();
    check("post_b_edge", 32'(b_pulse), 32'd1);
    b_sig = 2'b00;
    tick();
    check("post_b_count", 32'(b_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
